reg_dump_reader: RTL and testbench

Debug read-out engine for the 32x32 integer register file. On a start pulse it walks register addresses 0..NUM_REGS-1 through the file's read port. It captures each value and streams it out on a valid/ready interface, with the register index and a last flag. It sits beside the core datapath and drives a dedicated debug read-address port (rs_addr) into the register file, muxed with rs2 by the top level while busy=1.

---
 rtl/reg_dump_reader_pkg.sv | 15 +
 rtl/reg_dump_reader.sv | 120 ++++++++++++
 tb/tb_reg_dump_reader.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared debug-dump definitions: state encoding and default register-file geometry.
package reg_dump_reader_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_NUM_REGS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks the register file through a dedicated read port
// and streams each captured value out on a valid/ready interface.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rs_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_idx,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state, state_nxt;
    logic [ADDR_W-1:0] rs_addr_nxt;
    logic              dump_valid_nxt;
    logic [DATA_W-1:0] dump_data_nxt;
    logic [ADDR_W-1:0] dump_idx_nxt;
    logic              dump_last_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rs_addr    <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_idx   <= '0;
            dump_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            rs_addr    <= rs_addr_nxt;
            dump_valid <= dump_valid_nxt;
            dump_data  <= dump_data_nxt;
            dump_idx   <= dump_idx_nxt;
            dump_last  <= dump_last_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    // Next-state and next-output logic; abort outranks a same-cycle handshake
    always_comb begin
        state_nxt      = state;
        rs_addr_nxt    = rs_addr;
        dump_valid_nxt = dump_valid;
        dump_data_nxt  = dump_data;
        dump_idx_nxt   = dump_idx;
        dump_last_nxt  = dump_last;
        busy_nxt       = busy;
        done_nxt       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    rs_addr_nxt = '0;
                    busy_nxt    = 1'b1;
                    state_nxt   = ST_READ;
                end
            end
            ST_READ: begin
                if (abort) begin
                    dump_valid_nxt = 1'b0;
                    busy_nxt       = 1'b0;
                    rs_addr_nxt    = '0;
                    state_nxt      = ST_IDLE;
                end else begin
                    dump_data_nxt  = rd_data;
                    dump_idx_nxt   = rs_addr;
                    dump_last_nxt  = (rs_addr == LAST_ADDR);
                    dump_valid_nxt = 1'b1;
                    state_nxt      = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    dump_valid_nxt = 1'b0;
                    busy_nxt       = 1'b0;
                    rs_addr_nxt    = '0;
                    state_nxt      = ST_IDLE;
                end else if (dump_ready) begin
                    dump_valid_nxt = 1'b0;
                    if (dump_last) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        rs_addr_nxt = rs_addr + ADDR_W'(1);
                        state_nxt   = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                busy_nxt    = 1'b0;
                rs_addr_nxt = '0;
                state_nxt   = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader with a behavioural register-file model.
module tb_reg_dump_reader;
    import reg_dump_reader_pkg::*;

    localparam int unsigned DW = DEF_DATA_W;
    localparam int unsigned AW = DEF_ADDR_W;
    localparam int unsigned NR = DEF_NUM_REGS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] rs_addr;
    logic [DW-1:0] rd_data;
    logic          dump_valid;
    logic          dump_ready;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_idx;
    logic          dump_last;
    logic          busy;
    logic          done;

    reg_dump_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .rs_addr    (rs_addr),
        .rd_data    (rd_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx),
        .dump_last  (dump_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read, writes applied by the bench on negedge
    logic [DW-1:0] regs [NR];
    logic [DW-1:0] exp_regs [NR];
    assign rd_data = regs[rs_addr];

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } word_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        logic          last;
    } vec_t;

    word_t got_q[$];
    int    done_cnt;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: accepted words, done pulses, and hold-during-stall
    logic  stall_q = 1'b0;
    word_t stall_w;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q)
                check("stall_hold", {32'd0, dump_valid, dump_last, dump_idx, dump_data},
                      {32'd0, 1'b1, stall_w.last, stall_w.idx, stall_w.data});
            if (dump_valid && dump_ready && !abort)
                got_q.push_back('{dump_data, dump_idx, dump_last});
            if (done)
                done_cnt++;
            stall_q = dump_valid && !dump_ready && !abort;
            stall_w = '{dump_data, dump_idx, dump_last};
        end
    end

    // Reference: word i carries the register value at dump start, index i, last on NR-1
    task automatic check_stream(input string name);
        check({name, "_count"}, 64'(got_q.size()), 64'(NR));
        for (int i = 0; i < int'(NR); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_word%0d", name, i),
                      {25'd0, got_q[i].last, got_q[i].idx, got_q[i].data},
                      {25'd0, (i == int'(NR) - 1), AW'(i), exp_regs[i]});
            end else begin
                n_checks++;
                n_errors++;
                $display("FAIL %s_word%0d: got nothing, expected a word", name, i);
            end
        end
    endtask

    task automatic run_dump(input bit rnd, input string name);
        int dk;
        dk = 0;
        for (int i = 0; i < int'(NR); i++) exp_regs[i] = regs[i];
        got_q.delete();
        done_cnt   = 0;
        start      = 1'b1;
        dump_ready = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            tick;
            start = rnd && ($urandom_range(0, 15) == 0);
            if (rnd) dump_ready = ($urandom_range(0, 9) < 6);
            if (done) begin
                dk    = k;
                start = 1'b0;
                break;
            end
        end
        start      = 1'b0;
        dump_ready = 1'b1;
        check({name, "_done_seen"}, 64'(dk != 0), 64'd1);
        tick;
        check({name, "_busy_after"}, 64'(busy), 64'd0);
        check({name, "_done_once"}, 64'(done_cnt), 64'd1);
        check_stream(name);
    endtask

    initial begin
        vec_t tbl[7];
        int   first_valid;
        int   done_k;
        int   stall;
        logic [DW-1:0] snap;

        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        dump_ready = 1'b0;
        for (int i = 0; i < int'(NR); i++) regs[i] = (i == 0) ? '0 : (32'hA5A50000 | DW'(i));
        regs[1]  = 32'h11111111;
        regs[5]  = 32'hDEADBEEF;
        regs[7]  = 32'hAAAA0007;
        regs[31] = 32'hCAFEF00D;

        tbl[0] = '{0,  32'h00000000, 1'b0};
        tbl[1] = '{1,  32'h11111111, 1'b0};
        tbl[2] = '{2,  32'hA5A50002, 1'b0};
        tbl[3] = '{5,  32'hDEADBEEF, 1'b0};
        tbl[4] = '{7,  32'h00000077, 1'b0};
        tbl[5] = '{30, 32'hA5A5001E, 1'b0};
        tbl[6] = '{31, 32'hCAFEF00D, 1'b1};

        #12;
        check("reset_outputs", {rs_addr, dump_valid, dump_data, dump_idx, dump_last, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        tick;
        check("idle_busy", 64'(busy), 64'd0);

        // Full dump with ready held, a concurrent write to x7, and a stray start mid-dump
        for (int i = 0; i < int'(NR); i++) exp_regs[i] = regs[i];
        exp_regs[7] = 32'h00000077;
        got_q.delete();
        done_cnt    = 0;
        first_valid = 0;
        done_k      = 0;
        dump_ready  = 1'b1;
        start       = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            tick;
            if (k == 1) begin
                start = 1'b0;
                check("busy_after_start", 64'(busy), 64'd1);
            end
            if (dump_valid && first_valid == 0) first_valid = k;
            if (k == 15) begin
                check("rs_addr_before_x7", 64'(rs_addr), 64'd7);
                @(negedge clk);
                regs[7] = 32'h00000077;
            end
            if (k == 16) begin
                @(negedge clk);
                regs[7] = 32'h12345678;
                #1;
                check("x7_held_after_write", 64'(dump_data), 64'h77);
            end
            if (k == 32) begin
                check("idx15_in_send", {dump_valid, dump_idx}, {1'b1, 5'd15});
                start = 1'b1;
            end
            if (k == 33) start = 1'b0;
            if (done) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;
        check("first_valid_latency", 64'(first_valid), 64'd2);
        check("done_latency", 64'(done_k), 64'd65);
        tick;
        check("busy_fall", {busy, done}, 64'd0);
        check("done_once", 64'(done_cnt), 64'd1);
        check_stream("full");
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].idx < got_q.size())
                check($sformatf("tbl_idx%0d", tbl[i].idx),
                      {got_q[tbl[i].idx].last, got_q[tbl[i].idx].data},
                      {tbl[i].last, tbl[i].data});
            else begin
                n_checks++;
                n_errors++;
                $display("FAIL tbl_idx%0d: got nothing, expected a word", tbl[i].idx);
            end
        end

        // Backpressure: hold ready low for 5 cycles on idx 3
        for (int i = 0; i < int'(NR); i++) exp_regs[i] = regs[i];
        got_q.delete();
        done_cnt   = 0;
        stall      = 0;
        snap       = '0;
        dump_ready = 1'b1;
        start      = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick;
            start = 1'b0;
            if (dump_valid && dump_idx == 5'd3 && stall < 5) begin
                check("bp_rs_addr", 64'(rs_addr), 64'd3);
                if (stall == 0) snap = dump_data;
                else check("bp_data", 64'(dump_data), 64'(snap));
                dump_ready = 1'b0;
                stall++;
            end else begin
                dump_ready = 1'b1;
            end
            if (done) break;
        end
        dump_ready = 1'b1;
        tick;
        check("bp_stall_cycles", 64'(stall), 64'd5);
        check("bp_done_once", 64'(done_cnt), 64'd1);
        check_stream("bp");

        // Abort while idx 10 is offered with ready high
        got_q.delete();
        done_cnt = 0;
        start    = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            tick;
            start = 1'b0;
            if (dump_valid && dump_idx == 5'd10) begin
                abort = 1'b1;
                tick;
                abort = 1'b0;
                check("abort_outputs", {dump_valid, busy, done, rs_addr}, 64'd0);
                break;
            end
        end
        tick;
        tick;
        tick;
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_words", 64'(got_q.size()), 64'd10);
        check("abort_idle", {busy, dump_valid}, 64'd0);
        run_dump(1'b0, "after_abort");

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", {busy, dump_valid}, 64'd0);
        tick;
        check("start_abort_busy2", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of SEND
        start      = 1'b1;
        dump_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            start = 1'b0;
            if (dump_valid && dump_idx == 5'd0) break;
        end
        check("pre_reset_valid", 64'(dump_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {rs_addr, dump_valid, dump_data, dump_idx, dump_last, busy, done}, 64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        dump_ready = 1'b1;
        tick;
        tick;
        tick;
        check("post_reset_idle", {busy, dump_valid, done}, 64'd0);

        // Randomized contents and backpressure against the reference stream
        for (int it = 0; it < 4; it++) begin
            for (int i = 1; i < int'(NR); i++) regs[i] = $urandom;
            run_dump(1'b1, $sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
